// File: rtl/computer_pkg.sv
// computer_pkg: shared widths, instruction field positions and opcodes for sc_computer.
`default_nettype none

package computer_pkg;
  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int RAW  = 3;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 9;
  localparam int DR_MSB  = 8;
  localparam int DR_LSB  = 6;
  localparam int SA_MSB  = 5;
  localparam int SA_LSB  = 3;
  localparam int SB_MSB  = 2;
  localparam int SB_LSB  = 0;

  localparam logic [6:0] OP_MOVA = 7'b0000000;
  localparam logic [6:0] OP_INC  = 7'b0000001;
  localparam logic [6:0] OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_SUB  = 7'b0000101;
  localparam logic [6:0] OP_DEC  = 7'b0000110;
  localparam logic [6:0] OP_AND  = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001;
  localparam logic [6:0] OP_XOR  = 7'b0001010;
  localparam logic [6:0] OP_NOT  = 7'b0001011;
  localparam logic [6:0] OP_MOVB = 7'b0001100;
  localparam logic [6:0] OP_SHR  = 7'b0001101;
  localparam logic [6:0] OP_SHL  = 7'b0001110;
  localparam logic [6:0] OP_LDI  = 7'b1001100;
  localparam logic [6:0] OP_ADI  = 7'b1000010;
  localparam logic [6:0] OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000;
  localparam logic [6:0] OP_BRZ  = 7'b1100000;
  localparam logic [6:0] OP_BRN  = 7'b1100001;
  localparam logic [6:0] OP_JMP  = 7'b1110000;
  localparam logic [6:0] OP_HLT  = 7'b1111111;
endpackage

`default_nettype wire

// File: rtl/sc_processor.sv
// sc_processor: PC, register file, decoder, ALU/shifter and instruction memory.
// Optional CPU_HALT_EN makes opcode 1111111 a halt (PC holds, no writes).
`default_nettype none

module sc_processor
  import computer_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic [DW-1:0]      o_dmem_wdata,
  output logic               o_dmem_we,
  input  logic [DW-1:0]      i_dmem_rdata
);

  reg [DW-1:0] instmem [0:2**IMEM_AW-1];

  logic [IMEM_AW-1:0] r_pc;
  logic [DW-1:0]      r_regs [0:NREG-1];

  logic [DW-1:0]      w_instr;
  logic [6:0]         w_opc;
  logic [RAW-1:0]     w_dr;
  logic [RAW-1:0]     w_sa;
  logic [RAW-1:0]     w_sb;
  logic [5:0]         w_ad;
  logic [DW-1:0]      w_a;
  logic [DW-1:0]      w_b;
  logic [DW-1:0]      w_imm;
  logic [IMEM_AW-1:0] w_pc_inc;
  logic [IMEM_AW-1:0] w_br_target;
  logic [IMEM_AW-1:0] w_pc_next;
  logic [DW-1:0]      w_result;
  logic               w_reg_we;
  logic               w_mem_we;

  assign w_instr     = instmem[r_pc];
  assign w_opc       = w_instr[OPC_MSB:OPC_LSB];
  assign w_dr        = w_instr[DR_MSB:DR_LSB];
  assign w_sa        = w_instr[SA_MSB:SA_LSB];
  assign w_sb        = w_instr[SB_MSB:SB_LSB];
  assign w_ad        = {w_dr, w_sb};
  assign w_a         = r_regs[w_sa];
  assign w_b         = r_regs[w_sb];
  assign w_imm       = {{(DW-RAW){1'b0}}, w_sb};
  assign w_pc_inc    = r_pc + 1'b1;
  assign w_br_target = r_pc + {{(IMEM_AW-6){w_ad[5]}}, w_ad};

  always_comb begin
    w_result  = '0;
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_pc_next = w_pc_inc;
    case (w_opc)
      OP_MOVA: begin w_result = w_a;                        w_reg_we = 1'b1; end
      OP_INC:  begin w_result = w_a + 1'b1;                 w_reg_we = 1'b1; end
      OP_ADD:  begin w_result = w_a + w_b;                  w_reg_we = 1'b1; end
      OP_SUB:  begin w_result = w_a - w_b;                  w_reg_we = 1'b1; end
      OP_DEC:  begin w_result = w_a - 1'b1;                 w_reg_we = 1'b1; end
      OP_AND:  begin w_result = w_a & w_b;                  w_reg_we = 1'b1; end
      OP_OR:   begin w_result = w_a | w_b;                  w_reg_we = 1'b1; end
      OP_XOR:  begin w_result = w_a ^ w_b;                  w_reg_we = 1'b1; end
      OP_NOT:  begin w_result = ~w_a;                       w_reg_we = 1'b1; end
      OP_MOVB: begin w_result = w_b;                        w_reg_we = 1'b1; end
      OP_SHR:  begin w_result = {1'b0, w_b[DW-1:1]};        w_reg_we = 1'b1; end
      OP_SHL:  begin w_result = {w_b[DW-2:0], 1'b0};        w_reg_we = 1'b1; end
      OP_LDI:  begin w_result = w_imm;                      w_reg_we = 1'b1; end
      OP_ADI:  begin w_result = w_a + w_imm;                w_reg_we = 1'b1; end
      OP_LD:   begin w_result = i_dmem_rdata;               w_reg_we = 1'b1; end
      OP_ST:   w_mem_we = 1'b1;
      OP_BRZ:  if (w_a == '0) w_pc_next = w_br_target;
      OP_BRN:  if (w_a[DW-1]) w_pc_next = w_br_target;
      OP_JMP:  w_pc_next = w_a[IMEM_AW-1:0];
`ifdef CPU_HALT_EN
      OP_HLT:  w_pc_next = r_pc;
`endif
      default: ;
    endcase
  end

  assign o_dmem_addr  = w_a[DMEM_AW-1:0];
  assign o_dmem_wdata = w_b;
  assign o_dmem_we    = w_mem_we;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_reg_we) r_regs[w_dr] <= w_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sc_computer.sv
// sc_computer: single-cycle 16-bit computer top; processor P1 plus data memory.
// Optional CPU_HALT_EN enables the HLT opcode inside P1.
`default_nettype none

module sc_computer
  import computer_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic CLK,
  input  logic RESET
);

  logic [DW-1:0]      r_dmem [0:2**DMEM_AW-1];
  logic [DMEM_AW-1:0] w_dmem_addr;
  logic [DW-1:0]      w_dmem_wdata;
  logic [DW-1:0]      w_dmem_rdata;
  logic               w_dmem_we;

  sc_processor #(
    .IMEM_AW (IMEM_AW),
    .DMEM_AW (DMEM_AW)
  ) P1 (
    .i_clk        (CLK),
    .i_rst_n      (RESET),
    .o_dmem_addr  (w_dmem_addr),
    .o_dmem_wdata (w_dmem_wdata),
    .o_dmem_we    (w_dmem_we),
    .i_dmem_rdata (w_dmem_rdata)
  );

  assign w_dmem_rdata = r_dmem[w_dmem_addr];

  // No reset: memory contents survive RESET.
  always_ff @(posedge CLK) begin
    if (w_dmem_we) r_dmem[w_dmem_addr] <= w_dmem_wdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_sc_computer.sv
// tb_sc_computer: directed programs loaded via P1.instmem, checked against hand-computed values.
`default_nettype none

module tb_sc_computer;
  import computer_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  sc_computer dut (.CLK(CLK), .RESET(RESET));

  always #5 CLK = ~CLK;

  localparam logic [15:0] NOP = 16'h0E00;

  function automatic logic [15:0] enc(input logic [6:0] op, input logic [2:0] dr,
                                      input logic [2:0] sa, input logic [2:0] sb);
    return {op, dr, sa, sb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) dut.P1.instmem[i] = NOP;
  endtask

  task automatic restart();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] pc();
    return {24'h0, dut.P1.r_pc};
  endfunction

  function automatic logic [31:0] rg(input int i);
    return {16'h0, dut.P1.r_regs[i]};
  endfunction

  initial begin
    // Reset state
    #2;
    chk("reset_pc", pc(), 32'h0);
    chk("reset_r3", rg(3), 32'h0);

    // Program 1: load/store/immediate/add with old-value read
    clear_prog();
    dut.P1.instmem[0] = enc(OP_LDI, 3'd3, 3'd0, 3'd3);
    dut.P1.instmem[1] = enc(OP_LDI, 3'd4, 3'd0, 3'd6);
    dut.P1.instmem[2] = enc(OP_ST,  3'd0, 3'd3, 3'd4);
    dut.P1.instmem[3] = enc(OP_LD,  3'd2, 3'd3, 3'd0);
    dut.P1.instmem[4] = enc(OP_ADI, 3'd2, 3'd2, 3'd1);
    dut.P1.instmem[5] = enc(OP_ADD, 3'd3, 3'd2, 3'd3);
    restart();
    step(1);
    chk("p1_first_pc", pc(), 32'd1);
    chk("p1_first_r3", rg(3), 32'd3);
    step(5);
    chk("p1_m3", {16'h0, dut.r_dmem[3]}, 32'd6);
    chk("p1_r2", rg(2), 32'd7);
    chk("p1_r3", rg(3), 32'd10);
    chk("p1_r4", rg(4), 32'd6);
    chk("p1_pc", pc(), 32'd6);

    // Mid-program reset of the same program
    restart();
    step(4);
    chk("p5_pre_r2", rg(2), 32'd6);
    RESET = 1'b0;
    #1;
    chk("p5_async_pc", pc(), 32'd0);
    chk("p5_async_r2", rg(2), 32'd0);
    chk("p5_async_r4", rg(4), 32'd0);
    chk("p5_m3_kept", {16'h0, dut.r_dmem[3]}, 32'd6);
    chk("p5_imem_kept", {16'h0, dut.P1.instmem[0]}, {16'h0, enc(OP_LDI, 3'd3, 3'd0, 3'd3)});
    @(negedge CLK);
    RESET = 1'b1;
    step(1);
    chk("p5_restart_pc", pc(), 32'd1);
    chk("p5_restart_r3", rg(3), 32'd3);

    // Program 2: BRZ taken
    clear_prog();
    dut.P1.instmem[0] = enc(OP_LDI, 3'd1, 3'd0, 3'd0);
    dut.P1.instmem[1] = enc(OP_BRZ, 3'd0, 3'd1, 3'd3);
    restart();
    step(1);
    chk("brz_pc1", pc(), 32'd1);
    step(1);
    chk("brz_taken_pc", pc(), 32'd4);
    // BRZ not taken
    dut.P1.instmem[0] = enc(OP_LDI, 3'd1, 3'd0, 3'd5);
    restart();
    step(2);
    chk("brz_fall_pc", pc(), 32'd2);

    // Program 3: SUB negative result, BRN backwards
    clear_prog();
    dut.P1.instmem[0] = enc(OP_LDI, 3'd1, 3'd0, 3'd7);
    dut.P1.instmem[1] = enc(OP_SUB, 3'd2, 3'd0, 3'd1);
    dut.P1.instmem[2] = enc(OP_BRN, 3'b111, 3'd2, 3'b110);
    restart();
    step(2);
    chk("sub_r2", rg(2), 32'h0000FFF9);
    step(1);
    chk("brn_pc", pc(), 32'd0);

    // Program 4: shifts and NOT
    clear_prog();
    dut.P1.instmem[0] = enc(OP_LDI, 3'd1, 3'd0, 3'd5);
    dut.P1.instmem[1] = enc(OP_SHL, 3'd2, 3'd0, 3'd1);
    dut.P1.instmem[2] = enc(OP_SHR, 3'd3, 3'd0, 3'd1);
    dut.P1.instmem[3] = enc(OP_NOT, 3'd4, 3'd1, 3'd0);
    restart();
    step(4);
    chk("shl_r2", rg(2), 32'd10);
    chk("shr_r3", rg(3), 32'd2);
    chk("not_r4", rg(4), 32'h0000FFFA);

    // Program 7: logic ops, INC/DEC, moves, undefined NOP, JMP
    clear_prog();
    dut.P1.instmem[0] = enc(OP_LDI,  3'd1, 3'd0, 3'd6);
    dut.P1.instmem[1] = enc(OP_LDI,  3'd2, 3'd0, 3'd3);
    dut.P1.instmem[2] = enc(OP_AND,  3'd3, 3'd1, 3'd2);
    dut.P1.instmem[3] = enc(OP_OR,   3'd4, 3'd1, 3'd2);
    dut.P1.instmem[4] = enc(OP_XOR,  3'd5, 3'd1, 3'd2);
    dut.P1.instmem[5] = enc(OP_DEC,  3'd6, 3'd1, 3'd0);
    dut.P1.instmem[6] = enc(OP_INC,  3'd7, 3'd2, 3'd0);
    dut.P1.instmem[7] = enc(OP_MOVB, 3'd0, 3'd0, 3'd1);
    dut.P1.instmem[8] = enc(OP_MOVA, 3'd1, 3'd7, 3'd0);
    dut.P1.instmem[9] = enc(7'b0000111, 3'd2, 3'd1, 3'd1);
    dut.P1.instmem[10] = enc(OP_LDI, 3'd5, 3'd0, 3'd7);
    dut.P1.instmem[11] = enc(OP_JMP, 3'd0, 3'd5, 3'd0);
    restart();
    step(10);
    chk("and_r3", rg(3), 32'd2);
    chk("or_r4", rg(4), 32'd7);
    chk("xor_r5", rg(5), 32'd5);
    chk("dec_r6", rg(6), 32'd5);
    chk("inc_r7", rg(7), 32'd4);
    chk("movb_r0", rg(0), 32'd6);
    chk("mova_r1", rg(1), 32'd4);
    chk("undef_r2", rg(2), 32'd3);
    chk("undef_pc", pc(), 32'd10);
    step(2);
    chk("jmp_pc", pc(), 32'd7);

    // Program 6: opcode 1111111 at address 2
    clear_prog();
    dut.P1.instmem[2] = 16'hFE00;
    restart();
    step(3);
`ifdef CPU_HALT_EN
    chk("hlt_pc3", pc(), 32'd2);
    step(10);
    chk("hlt_pc13", pc(), 32'd2);
`else
    chk("hlt_pc3", pc(), 32'd3);
    step(10);
    chk("hlt_pc13", pc(), 32'd13);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
